// File: rtl/bats_seq_unit_filter.sv
// bats_seq_unit_filter: sequenced-unit gate in front of the BATS parser.
// Inspects the Sequenced Unit Header at the start of each UDP datagram. New or
// in-order datagrams are forwarded unchanged. Duplicates, heartbeats and
// malformed headers are discarded. Sequence gaps produce a one-cycle report.
// Optional build macro: BATS_SEQ_STATS_EN enables the saturating statistics
// counters. When it is undefined, the stat_* ports are tied to zero.

module bats_seq_unit_filter #(
    parameter int unsigned NUM_UNITS = 8
) (
    input  logic        Clk40,
    input  logic        reset_n,
    input  logic        sync_clear,
    input  logic [63:0] in_bytes,
    input  logic [7:0]  in_byte_enables,
    input  logic        in_data_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] out_bytes,
    output logic [7:0]  out_byte_enables,
    output logic        out_data_valid,
    input  logic        out_ready,
    output logic        gap_valid,
    output logic [7:0]  gap_unit,
    output logic [31:0] gap_size,
    output logic [31:0] stat_fwd_dgrams,
    output logic [31:0] stat_dup_dgrams,
    output logic [31:0] stat_gap_events,
    output logic [31:0] stat_malformed
);

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BE_W    = 8;
    localparam int unsigned SEQ_W   = 32;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STAT_W  = 32;
    localparam int unsigned UNIT_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned MIN_HDR = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Output stage registers
    logic [DATA_W-1:0] out_bytes_q;
    logic [BE_W-1:0]   out_be_q;
    logic              out_valid_q;
    logic              gap_valid_q;
    logic [BYTE_W-1:0] gap_unit_q;
    logic [SEQ_W-1:0]  gap_size_q;

    // Expected-next-sequence table, zero means the unit is not yet synced
    logic [SEQ_W-1:0] tbl_q [NUM_UNITS];

    // Header fields, little-endian over byte0 = [63:56]
    logic [BYTE_W-1:0] b0, b1, b2, b3, b4, b5, b6, b7;
    logic [LEN_W-1:0]  hdr_len;
    logic [BYTE_W-1:0] hdr_count;
    logic [BYTE_W-1:0] hdr_unit;
    logic [SEQ_W-1:0]  hdr_seq;
    logic [UNIT_W-1:0] unit_idx;
    logic [SEQ_W-1:0]  exp_seq;
    logic [SEQ_W-1:0]  nxt_seq;
    logic              hdr_malformed;

    // Decisions produced by the next-state logic
    logic accept;
    logic fwd_word;
    logic tbl_we;
    logic gap_set;
    logic ev_fwd;
    logic ev_dup;
    logic ev_mal;

    // Header field extraction
    always_comb begin
        b0        = in_bytes[63:56];
        b1        = in_bytes[55:48];
        b2        = in_bytes[47:40];
        b3        = in_bytes[39:32];
        b4        = in_bytes[31:24];
        b5        = in_bytes[23:16];
        b6        = in_bytes[15:8];
        b7        = in_bytes[7:0];
        hdr_len   = {b1, b0};
        hdr_count = b2;
        hdr_unit  = b3;
        hdr_seq   = {b7, b6, b5, b4};
        unit_idx  = hdr_unit[UNIT_W-1:0];
        exp_seq   = tbl_q[unit_idx];
        nxt_seq   = hdr_seq + SEQ_W'(hdr_count);
        hdr_malformed = (in_byte_enables != 8'hFF)
                      || (hdr_len < LEN_W'(MIN_HDR))
                      || (SEQ_W'(hdr_unit) >= SEQ_W'(NUM_UNITS));
    end

    // The drop state sinks words freely; otherwise the single output stage gates input
    assign in_ready = (state_q == ST_DROP) || !out_valid_q || out_ready;
    assign accept   = in_data_valid && in_ready;

    // FSM state register
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-datagram decision on the header word
    always_comb begin
        state_d  = state_q;
        fwd_word = 1'b0;
        tbl_we   = 1'b0;
        gap_set  = 1'b0;
        ev_fwd   = 1'b0;
        ev_dup   = 1'b0;
        ev_mal   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_malformed) begin
                        ev_mal = 1'b1;
                        if (!in_last) state_d = ST_DROP;
                    end else if (hdr_count == '0) begin
                        if (!in_last) state_d = ST_DROP;
                    end else if (hdr_unit == '0) begin
                        fwd_word = 1'b1;
                        ev_fwd   = 1'b1;
                        if (!in_last) state_d = ST_FWD;
                    end else if ((exp_seq != '0) && (nxt_seq <= exp_seq)) begin
                        ev_dup = 1'b1;
                        if (!in_last) state_d = ST_DROP;
                    end else begin
                        fwd_word = 1'b1;
                        ev_fwd   = 1'b1;
                        tbl_we   = 1'b1;
                        gap_set  = (exp_seq != '0) && (hdr_seq > exp_seq);
                        if (!in_last) state_d = ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (accept) begin
                    fwd_word = 1'b1;
                    if (in_last) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && in_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (sync_clear) begin
            state_d  = ST_IDLE;
            fwd_word = 1'b0;
            tbl_we   = 1'b0;
            gap_set  = 1'b0;
            ev_fwd   = 1'b0;
            ev_dup   = 1'b0;
            ev_mal   = 1'b0;
        end
    end

    // Single-stage output register and gap report
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            out_bytes_q <= '0;
            out_be_q    <= '0;
            out_valid_q <= 1'b0;
            gap_valid_q <= 1'b0;
            gap_unit_q  <= '0;
            gap_size_q  <= '0;
        end else if (sync_clear) begin
            out_bytes_q <= '0;
            out_be_q    <= '0;
            out_valid_q <= 1'b0;
            gap_valid_q <= 1'b0;
            gap_unit_q  <= '0;
            gap_size_q  <= '0;
        end else begin
            if (fwd_word) begin
                out_bytes_q <= in_bytes;
                out_be_q    <= in_byte_enables;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            gap_valid_q <= gap_set;
            if (gap_set) begin
                gap_unit_q <= hdr_unit;
                gap_size_q <= hdr_seq - exp_seq;
            end
        end
    end

    // Expected-sequence table update
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_UNITS; i++) tbl_q[i] <= '0;
        end else if (sync_clear) begin
            for (int i = 0; i < NUM_UNITS; i++) tbl_q[i] <= '0;
        end else if (tbl_we) begin
            tbl_q[unit_idx] <= nxt_seq;
        end
    end

    assign out_bytes        = out_bytes_q;
    assign out_byte_enables = out_be_q;
    assign out_data_valid   = out_valid_q;
    assign gap_valid        = gap_valid_q;
    assign gap_unit         = gap_unit_q;
    assign gap_size         = gap_size_q;

`ifdef BATS_SEQ_STATS_EN
    logic [STAT_W-1:0] fwd_cnt_q, dup_cnt_q, gap_cnt_q, mal_cnt_q;

    // Saturating datagram statistics
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            fwd_cnt_q <= '0;
            dup_cnt_q <= '0;
            gap_cnt_q <= '0;
            mal_cnt_q <= '0;
        end else if (sync_clear) begin
            fwd_cnt_q <= '0;
            dup_cnt_q <= '0;
            gap_cnt_q <= '0;
            mal_cnt_q <= '0;
        end else begin
            if (ev_fwd && (fwd_cnt_q != '1)) fwd_cnt_q <= fwd_cnt_q + STAT_W'(1);
            if (ev_dup && (dup_cnt_q != '1)) dup_cnt_q <= dup_cnt_q + STAT_W'(1);
            if (gap_set && (gap_cnt_q != '1)) gap_cnt_q <= gap_cnt_q + STAT_W'(1);
            if (ev_mal && (mal_cnt_q != '1)) mal_cnt_q <= mal_cnt_q + STAT_W'(1);
        end
    end

    assign stat_fwd_dgrams = fwd_cnt_q;
    assign stat_dup_dgrams = dup_cnt_q;
    assign stat_gap_events = gap_cnt_q;
    assign stat_malformed  = mal_cnt_q;
`else
    logic unused_stat_events;
    assign unused_stat_events = ^{ev_fwd, ev_dup, ev_mal};

    assign stat_fwd_dgrams = '0;
    assign stat_dup_dgrams = '0;
    assign stat_gap_events = '0;
    assign stat_malformed  = '0;
`endif

endmodule

// File: tb/tb_bats_seq_unit_filter.sv
// Directed bench for bats_seq_unit_filter (NUM_UNITS = 8).

module tb_bats_seq_unit_filter;

`ifdef BATS_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int WAIT_LIMIT = 50;

    logic        clk;
    logic        rst_n;
    logic        sync_clear;
    logic [63:0] in_bytes;
    logic [7:0]  in_be;
    logic        in_dv;
    logic        in_last;
    logic        in_ready;
    logic [63:0] out_bytes;
    logic [7:0]  out_be;
    logic        out_dv;
    logic        out_ready;
    logic        gap_valid;
    logic [7:0]  gap_unit;
    logic [31:0] gap_size;
    logic [31:0] st_fwd, st_dup, st_gap, st_mal;

    int checks = 0;
    int passed = 0;
    logic [63:0] beats[$];

    bats_seq_unit_filter #(.NUM_UNITS(8)) dut (
        .Clk40            (clk),
        .reset_n          (rst_n),
        .sync_clear       (sync_clear),
        .in_bytes         (in_bytes),
        .in_byte_enables  (in_be),
        .in_data_valid    (in_dv),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .out_bytes        (out_bytes),
        .out_byte_enables (out_be),
        .out_data_valid   (out_dv),
        .out_ready        (out_ready),
        .gap_valid        (gap_valid),
        .gap_unit         (gap_unit),
        .gap_size         (gap_size),
        .stat_fwd_dgrams  (st_fwd),
        .stat_dup_dgrams  (st_dup),
        .stat_gap_events  (st_gap),
        .stat_malformed   (st_mal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word the parser actually takes
    always @(negedge clk) begin
        if (out_dv && out_ready) beats.push_back(out_bytes);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; returns 1 ns after the accepting edge
    task automatic drive(input logic [63:0] b, input logic [7:0] be, input logic last);
        int n;
        n = 0;
        in_bytes = b;
        in_be    = be;
        in_last  = last;
        in_dv    = 1'b1;
        while (!in_ready && n < WAIT_LIMIT) begin
            step();
            n++;
        end
        check("accept_timeout", 64'(n < WAIT_LIMIT), 64'd1);
        step();
        in_dv   = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int f, input int d, input int g, input int m);
        check({tag, "_fwd"}, 64'(st_fwd), STATS ? 64'(f) : 64'd0);
        check({tag, "_dup"}, 64'(st_dup), STATS ? 64'(d) : 64'd0);
        check({tag, "_gap"}, 64'(st_gap), STATS ? 64'(g) : 64'd0);
        check({tag, "_mal"}, 64'(st_mal), STATS ? 64'(m) : 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        sync_clear = 1'b0;
        in_bytes   = '0;
        in_be      = '0;
        in_dv      = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_out_dv", 64'(out_dv), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_bytes", out_bytes, 64'd0);
        check("rst_gap_valid", 64'(gap_valid), 64'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check_stats("rst", 0, 0, 0, 0);
        beats.delete();

        // 1: unit1 seq2 count1, two words, forwarded with one-cycle latency
        drive(64'h0E00010102000000, 8'hFF, 1'b0);
        check("t1_hdr_dv", 64'(out_dv), 64'd1);
        check("t1_hdr_bytes", out_bytes, 64'h0E00010102000000);
        check("t1_hdr_be", 64'(out_be), 64'hFF);
        check("t1_hdr_nogap", 64'(gap_valid), 64'd0);
        drive(64'h1122334455660000, 8'hFC, 1'b1);
        check("t1_body_bytes", out_bytes, 64'h1122334455660000);
        check("t1_body_be", 64'(out_be), 64'hFC);
        step();
        check("t1_drain_dv", 64'(out_dv), 64'd0);

        // 2: identical resend is a duplicate
        drive(64'h0E00010102000000, 8'hFF, 1'b0);
        check("t2_hdr_dv", 64'(out_dv), 64'd0);
        check("t2_in_ready", 64'(in_ready), 64'd1);
        drive(64'h1122334455660000, 8'hFC, 1'b1);
        check("t2_body_dv", 64'(out_dv), 64'd0);
        step();
        check("t2_beats", 64'(beats.size()), 64'd2);
        if (beats.size() == 2) begin
            check("t2_beat0", beats[0], 64'h0E00010102000000);
            check("t2_beat1", beats[1], 64'h1122334455660000);
        end
        check_stats("t2", 1, 1, 0, 0);

        // 3: seq7 after expected 3 -> gap of 4 (single-word datagram)
        drive(64'h0E00010107000000, 8'hFF, 1'b1);
        check("t3_dv", 64'(out_dv), 64'd1);
        check("t3_gap_valid", 64'(gap_valid), 64'd1);
        check("t3_gap_unit", 64'(gap_unit), 64'd1);
        check("t3_gap_size", 64'(gap_size), 64'd4);
        step();
        check("t3_gap_pulse_end", 64'(gap_valid), 64'd0);

        // In-order seq8 count2 -> expected becomes 10, no gap
        drive(64'h0E00020108000000, 8'hFF, 1'b1);
        check("inorder_dv", 64'(out_dv), 64'd1);
        check("inorder_nogap", 64'(gap_valid), 64'd0);
        // Partial overlap seq9 count2 (nxt 11 > 10) -> forwarded, no gap
        drive(64'h0E00020109000000, 8'hFF, 1'b1);
        check("overlap_dv", 64'(out_dv), 64'd1);
        check("overlap_bytes", out_bytes, 64'h0E00020109000000);
        check("overlap_nogap", 64'(gap_valid), 64'd0);
        // seq10 count1 -> nxt 11 equals expected: duplicate
        drive(64'h0E0001010A000000, 8'hFF, 1'b1);
        check("dup_eq_dv", 64'(out_dv), 64'd0);

        // 4: heartbeat, then out-of-range unit 9, then short header length
        drive(64'h0E00000130000000, 8'hFF, 1'b1);
        check("t4_hb_dv", 64'(out_dv), 64'd0);
        drive(64'h0E00010912000000, 8'hFF, 1'b0);
        check("t4_unit9_dv", 64'(out_dv), 64'd0);
        check("t4_drop_in_ready", 64'(in_ready), 64'd1);
        drive(64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1);
        check("t4_unit9_body_dv", 64'(out_dv), 64'd0);
        check_stats("t4", 4, 2, 1, 1);
        drive(64'h0400010114000000, 8'hFF, 1'b1);
        check("short_len_dv", 64'(out_dv), 64'd0);
        // Unit 0 is unsequenced: always forwarded
        drive(64'h0E000100FFFFFFFF, 8'hFF, 1'b1);
        check("unit0_dv", 64'(out_dv), 64'd1);
        check("unit0_nogap", 64'(gap_valid), 64'd0);
        step();

        // 5: backpressure for 5 cycles in the middle of a forwarded datagram
        beats.delete();
        drive(64'h0E00010201000000, 8'hFF, 1'b0);
        out_ready = 1'b0;
        in_bytes  = 64'hA1A1A1A1A1A1A1A1;
        in_be     = 8'hFF;
        in_last   = 1'b0;
        in_dv     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_hold_bytes", out_bytes, 64'h0E00010201000000);
            check("t5_hold_dv", 64'(out_dv), 64'd1);
            check("t5_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("t5_release_in_ready", 64'(in_ready), 64'd1);
        step();
        in_dv = 1'b0;
        check("t5_w1_bytes", out_bytes, 64'hA1A1A1A1A1A1A1A1);
        drive(64'hB2B2B2B2B2B2B2B2, 8'hFF, 1'b0);
        drive(64'hC3C3C3C3C3000000, 8'hF8, 1'b1);
        check("t5_w3_be", 64'(out_be), 64'hF8);
        step();
        check("t5_beats", 64'(beats.size()), 64'd4);
        if (beats.size() == 4) begin
            check("t5_beat0", beats[0], 64'h0E00010201000000);
            check("t5_beat1", beats[1], 64'hA1A1A1A1A1A1A1A1);
            check("t5_beat2", beats[2], 64'hB2B2B2B2B2B2B2B2);
            check("t5_beat3", beats[3], 64'hC3C3C3C3C3000000);
        end
        check_stats("t5", 6, 2, 1, 2);

        // 6: sync_clear mid-datagram abandons it and clears the table
        drive(64'h0E0001010B000000, 8'hFF, 1'b0);
        check("t6_hdr_dv", 64'(out_dv), 64'd1);
        drive(64'h5555555555555555, 8'hFF, 1'b0);
        sync_clear = 1'b1;
        in_bytes   = 64'h6666666666666666;
        in_be      = 8'hFF;
        in_dv      = 1'b1;
        step();
        sync_clear = 1'b0;
        in_dv      = 1'b0;
        check("t6_clr_dv", 64'(out_dv), 64'd0);
        check("t6_clr_bytes", out_bytes, 64'd0);
        check_stats("t6_clr", 0, 0, 0, 0);
        // Trailing word of the abandoned datagram is seen as a bad header
        drive(64'h7777777777770000, 8'hFC, 1'b1);
        check("t6_tail_dv", 64'(out_dv), 64'd0);
        drive(64'h0E00010164000000, 8'hFF, 1'b1);
        check("t6_seq100_dv", 64'(out_dv), 64'd1);
        check("t6_seq100_bytes", out_bytes, 64'h0E00010164000000);
        check("t6_seq100_nogap", 64'(gap_valid), 64'd0);
        // Table now holds 101 for unit1: seq5 is stale
        drive(64'h0E00010105000000, 8'hFF, 1'b1);
        check("t6_stale_dv", 64'(out_dv), 64'd0);
        step();
        check_stats("t6_end", 1, 1, 0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
